// File: rtl/reg_file.sv
// 32 x 32-bit register file with two combinational read ports, x0 hard-wired to zero,
// and a valid/ready dump streamer. Define RF_BYPASS_EN for write-to-read forwarding.
package riscv_32i_defs_pkg;
  localparam int XLEN          = 32;
  localparam int RF_DEPTH      = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef logic [XLEN-1:0]          word_t;
  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

  localparam rf_addr_t X0 = '0;
endpackage

module reg_file
  import riscv_32i_defs_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [RF_ADDR_WIDTH-1:0] wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [RF_ADDR_WIDTH-1:0] rs1_addr,
  output logic [XLEN-1:0]          rs1_data,
  input  logic [RF_ADDR_WIDTH-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs2_data,
  input  logic                     dump_start,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [RF_ADDR_WIDTH-1:0] dump_addr,
  output logic [XLEN-1:0]          dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  // Dump handshake: a word transfers at any rising edge where dump_valid and
  // dump_ready are both 1; while dump_valid=1 and dump_ready=0 the word holds.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } dump_state_t;

  localparam rf_addr_t LAST_ADDR = rf_addr_t'(RF_DEPTH - 1);

  dump_state_t state;
  word_t       regs [RF_DEPTH];
  logic        wr_act;
  rf_addr_t    next_addr;
  word_t       cap_data;

  assign wr_act    = wr_en && (wr_addr != X0);
  assign next_addr = dump_addr + rf_addr_t'(1);

  always_comb begin
    rs1_data = (rs1_addr == X0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == X0) ? '0 : regs[rs2_addr];
    cap_data = regs[next_addr];
`ifdef RF_BYPASS_EN
    if (wr_act && (wr_addr == rs1_addr)) rs1_data = wr_data;
    if (wr_act && (wr_addr == rs2_addr)) rs2_data = wr_data;
    if (wr_act && (wr_addr == next_addr)) cap_data = wr_data;
`endif
  end

  // Entry 0 is cleared on reset and never written, so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else if (wr_act) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            state      <= STREAM;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_addr  <= X0;
            dump_data  <= '0;
          end
        end
        STREAM: begin
          if (dump_ready) begin
            if (dump_addr == LAST_ADDR) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_busy  <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_addr <= next_addr;
              dump_data <= cap_data;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: random reads/writes and dump streams compared
// against an array model of the register contents and an expected-word queue.
`timescale 1ns/1ps
module tb_reg_file;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs2_data;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b0;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  reg_file dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Drivers and model
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_write();
    if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && we && wa != 5'd0 && wa == a) return wd;
    return model[a];
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    commit_write();
    wr_en = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5; dump_start = 1'b1;
    step();
    step();
    rst = 1'b0; wr_en = 1'b0; dump_start = 1'b0;
    clear_model();
    checks++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 ||
        dump_addr !== 5'd0 || dump_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_dump_outputs got v=%b b=%b d=%b a=%0d data=%h exp all zero",
               dump_valid, dump_busy, dump_done, dump_addr, dump_data);
    end
    step();
    checks++;
    if (dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_priority got dump_valid=%b exp 0", dump_valid);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      checks++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_regs addr=%0d got rs1=%h rs2=%h exp 0", i, rs1_data, rs2_data);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd31, 32'h0BADF00D);
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF || rs2_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read_x5 got rs1=%h rs2=%h exp deadbeef", rs1_data, rs2_data);
    end
    rs1_addr = 5'd31; rs2_addr = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 32'h0BADF00D || rs2_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_ports_independent got rs1=%h rs2=%h exp 0badf00d deadbeef",
               rs1_data, rs2_data);
    end
  endtask

  task automatic test_x0();
    do_write(5'd0, 32'hFFFFFFFF);
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_read got rs1=%h rs2=%h exp 0", rs1_data, rs2_data);
    end
  endtask

  task automatic test_same_cycle();
    do_write(5'd7, 32'h00000001);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    checks++;
    if (rs1_data !== (BYPASS ? 32'h12345678 : 32'h00000001) || rs2_data !== rs1_data) begin
      errors++;
      $display("FAIL same_cycle_write got rs1=%h rs2=%h exp %h", rs1_data, rs2_data,
               BYPASS ? 32'h12345678 : 32'h00000001);
    end
    step();
    commit_write();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h12345678) begin
      errors++;
      $display("FAIL same_cycle_next got rs1=%h exp 12345678", rs1_data);
    end
  endtask

  task automatic test_random_rw();
    for (int n = 0; n < 80; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (rs1_data !== ref_read(rs1_addr, wr_en, wr_addr, wr_data)) begin
        errors++;
        $display("FAIL random_rs1 addr=%0d got %h exp %h", rs1_addr, rs1_data,
                 ref_read(rs1_addr, wr_en, wr_addr, wr_data));
      end
      checks++;
      if (rs2_data !== ref_read(rs2_addr, wr_en, wr_addr, wr_data)) begin
        errors++;
        $display("FAIL random_rs2 addr=%0d got %h exp %h", rs2_addr, rs2_data,
                 ref_read(rs2_addr, wr_en, wr_addr, wr_data));
      end
      step();
      commit_write();
    end
    wr_en = 1'b0;
  endtask

  // ready_mode: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random
  task automatic run_dump(input int ready_mode, input bit rand_writes);
    logic [3:0] pat;
    int  idx;
    int  cyc;
    bit  finished;
    pat = 4'b1001;
    idx = 0; cyc = 0; finished = 0;
    exp_q.delete();
    wr_en = 1'b0;
    dump_ready = 1'b0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    exp_q.push_back(32'h0);
    while (!finished && cyc < 400) begin
      checks++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_done !== 1'b0 ||
          dump_addr !== 5'(idx) || dump_data !== exp_q[0]) begin
        errors++;
        $display("FAIL dump_word mode=%0d cyc=%0d got v=%b b=%b d=%b a=%0d data=%h exp a=%0d data=%h",
                 ready_mode, cyc, dump_valid, dump_busy, dump_done, dump_addr, dump_data,
                 idx, exp_q[0]);
      end
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = pat[cyc % 4];
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      dump_start = 1'($urandom_range(0, 1));
      if (rand_writes) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = ($urandom_range(0, 2) == 0) ? 5'(idx + 1) : 5'($urandom_range(0, 31));
        wr_data = $urandom;
      end
      if (dump_ready) begin
        void'(exp_q.pop_front());
        if (idx < 31) exp_q.push_back(ref_read(5'(idx + 1), wr_en, wr_addr, wr_data));
      end
      step();
      commit_write();
      if (dump_ready) begin
        if (idx == 31) finished = 1;
        else idx++;
      end
      cyc++;
    end
    wr_en = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL dump_timeout mode=%0d got idx=%0d exp 31 within 400 cycles", ready_mode, idx);
    end else begin
      if (ready_mode == 0 && cyc != 32) begin
        errors++;
        $display("FAIL dump_length got %0d valid cycles exp 32", cyc);
      end
      dump_start = 1'b1;
      checks++;
      if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
        errors++;
        $display("FAIL dump_done_pulse got d=%b v=%b b=%b exp 1 0 0", dump_done, dump_valid, dump_busy);
      end
      step();
      dump_start = 1'b0;
      checks++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
        errors++;
        $display("FAIL dump_after_done got d=%b v=%b b=%b exp 0 0 0", dump_done, dump_valid, dump_busy);
      end
      step();
      checks++;
      if (dump_valid !== 1'b0 || dump_done !== 1'b0) begin
        errors++;
        $display("FAIL dump_start_in_done got v=%b d=%b exp 0 0", dump_valid, dump_done);
      end
    end
  endtask

  task automatic test_dump_full();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
    do_write(5'd0, 32'hFFFFFFFF);
    run_dump(0, 1'b0);
  endtask

  task automatic test_dump_stall();
    for (int i = 1; i < 32; i++) do_write(5'(i), $urandom);
    run_dump(1, 1'b0);
  endtask

  task automatic test_dump_random();
    run_dump(2, 1'b1);
    run_dump(0, 1'b1);
  endtask

  task automatic test_reset_mid_dump();
    int guard;
    for (int i = 1; i < 32; i++) do_write(5'(i), $urandom | 32'h1);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    guard = 0;
    while (dump_addr !== 5'd10 && guard < 40) begin
      step();
      guard++;
    end
    checks++;
    if (dump_addr !== 5'd10 || dump_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_dump_reach got a=%0d v=%b exp a=10 v=1", dump_addr, dump_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    checks++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_dump_abort got v=%b b=%b d=%b exp 0 0 0", dump_valid, dump_busy, dump_done);
    end
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_dump_no_done cyc=%0d got d=%b v=%b exp 0 0", n, dump_done, dump_valid);
      end
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      #1;
      checks++;
      if (rs1_data !== model[i]) begin
        errors++;
        $display("FAIL mid_dump_regs_clear addr=%0d got %h exp %h", i, rs1_data, model[i]);
      end
    end
  endtask

  // Sequence and report
  initial begin
    clear_model();
    test_reset();
    test_write_read();
    test_x0();
    test_same_cycle();
    test_random_rw();
    test_dump_full();
    test_dump_stall();
    test_dump_random();
    test_reset_mid_dump();
    test_random_rw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL take XLEN (32), RF_DEPTH (32), RF_ADDR_WIDTH (5) and X0 (0) from riscv_32i_defs_pkg, and SHALL have no module parameters.
- XLEN, default 32: data word width (word_t).
- RF_DEPTH, default 32: number of registers.
- RF_ADDR_WIDTH, default 5: register address width (rf_addr_t).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write enable
- wr_addr  in  5  write register address
- wr_data  in  32  write data
- rs1_addr  in  5  read port 1 address
- rs1_data  out  32  read port 1 data, combinational
- rs2_addr  in  5  read port 2 address
- rs2_data  out  32  read port 2 data, combinational
- dump_start  in  1  request a sequential readout of all registers
- dump_ready  in  1  consumer accepts dump word
- dump_valid  out  1  dump word valid
- dump_addr  out  5  address of the current dump word
- dump_data  out  32  contents of the current dump word
- dump_busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse after the last word is accepted

Function
REQ-003 The storage array SHALL hold 32 words; writes SHALL occur at the rising clk edge when wr_en=1 and wr_addr!=X0.
REQ-004 Writes to X0 SHALL be discarded, and every read of X0 (rs1, rs2, dump) SHALL return 0.
REQ-005 rs1_data and rs2_data SHALL be combinational from the array (zero-cycle latency), with both ports fully independent.
REQ-006 The dump FSM SHALL have three states: IDLE, STREAM and DONE.
REQ-007 IDLE: when dump_start=1, the FSM SHALL move to STREAM at the next edge, loading dump_addr=0 and dump_data=0 and asserting dump_valid=1.
REQ-008 STREAM: dump_busy=1 and dump_valid=1; dump_addr and dump_data SHALL stay stable while dump_valid=1 and dump_ready=0.
REQ-009 STREAM handshake (dump_valid & dump_ready at an edge) with dump_addr<31: dump_addr SHALL increment, and dump_data SHALL register the array contents at the new address as sampled at that edge.
REQ-010 STREAM handshake with dump_addr=31: the FSM SHALL move to DONE with dump_valid=0.
REQ-011 DONE SHALL last exactly one cycle with dump_done=1 and dump_busy=0, then return to IDLE unconditionally.
REQ-012 dump_start SHALL be ignored in STREAM and DONE; a new dump starts only from IDLE.
REQ-013 A write at the same edge a dump word is captured SHALL NOT appear in that word unless RF_BYPASS_EN is defined (REQ-017).
- Later words SHALL reflect all writes completed before their capture edge.
REQ-014 A full dump with dump_ready held at 1 SHALL take 32 consecutive valid cycles, with dump_done in cycle 33 after the first valid.

Reset
REQ-015 When rst=1 at an edge, the block SHALL clear all registers to 0, put the FSM in IDLE, and drive dump_valid, dump_busy, dump_done, dump_addr and dump_data to 0.
- rst SHALL have priority over wr_en and dump_start in the same cycle.
REQ-016 When rst=1 mid-dump, the block SHALL abort the stream in the next cycle with no dump_done pulse.

Configuration
REQ-017 RF_BYPASS_EN defined: when wr_en=1 and wr_addr!=X0 and wr_addr equals rs1_addr or rs2_addr, the matching read port SHALL return wr_data in the same cycle.
- The same bypass SHALL apply to a dump capture whose address equals wr_addr.
- With RF_BYPASS_EN undefined, reads SHALL return the pre-write array value and the write SHALL become visible the next cycle.

Verification
REQ-018 Write x5=0xDEADBEEF, then read rs1=5 and rs2=5 the next cycle -> both return 0xDEADBEEF.
REQ-019 Write x0=0xFFFFFFFF, then read rs1=0 -> returns 0x00000000; a dump word at addr 0 -> 0.
REQ-020 Same-cycle write of x7=0x12345678 with rs1_addr=7, while x7 previously held 0x1 -> returns 0x12345678 with RF_BYPASS_EN defined and 0x00000001 without.
REQ-021 Load x1..x31 with value=addr, pulse dump_start, hold dump_ready=1 -> 32 words with addr 0..31 and data 0..31, then one dump_done pulse.
REQ-022 Dump with dump_ready toggled 1,0,0,1 -> dump_addr and dump_data hold during stall cycles, and no word is skipped or duplicated.
REQ-023 Assert rst during a dump at dump_addr=10 -> the next cycle shows dump_valid=0 and dump_busy=0, no dump_done, and all registers read 0.
